// File: rtl/spi_pkg.sv
// Shared types and defaults for the 32-bit SPI receive link.
package spi_pkg;

  localparam int SPI_FRAME_W    = 32;
  localparam int SPI_SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT      = 2'd1,
    WAIT_DESEL = 2'd2
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with single-cycle rise/fall
// pulses derived from one extra register stage after the synchronised level.
module spi_sync_edge #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [DEPTH-1:0] sync_q;
  logic             prev_q;

  // Synchroniser chain plus the edge-detect history flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {DEPTH{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
      prev_q <= sync_q[DEPTH-1];
    end
  end

  assign q_o    = sync_q[DEPTH-1];
  assign rise_o = sync_q[DEPTH-1] & ~prev_q;
  assign fall_o = ~sync_q[DEPTH-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI receive slave: oversampled SCK/SSEL/MOSI, 32-bit frames to a parallel word.
// Define SPI_SLAVE_MISO_EN to build the MISO return path from tx_data.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_FRAME_W,
  parameter int SYNC_STAGES = SPI_SYNC_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              SCK,
  input  logic              SSEL,
  input  logic              DATA_IN,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic sck_rise, sck_fall, ssel_rise, ssel_fall, din_s;
  logic sck_lvl_unused, ssel_lvl_unused, din_rise_unused, din_fall_unused;

  spi_sync_edge #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
    .clk(clk), .reset_n(reset_n), .d_i(SCK),
    .q_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssel (
    .clk(clk), .reset_n(reset_n), .d_i(SSEL),
    .q_o(ssel_lvl_unused), .rise_o(ssel_rise), .fall_o(ssel_fall)
  );

  spi_sync_edge #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_din (
    .clk(clk), .reset_n(reset_n), .d_i(DATA_IN),
    .q_o(din_s), .rise_o(din_rise_unused), .fall_o(din_fall_unused)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Holds the first DATA_W-1 bits; the last bit joins directly on capture.
  logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              valid_pend_q, valid_pend_d;
  logic              frame_err_q, frame_err_d;
  logic              ovr_q, ovr_d;
  logic              rx_valid_q, busy_q;

  // Next-state, shift and strobe decisions.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    valid_pend_d = 1'b0;
    frame_err_d  = 1'b0;
    ovr_d        = ovr_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ssel_fall) begin
            state_d = SHIFT;
            cnt_d   = '0;
            ovr_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            cnt_d      = cnt_q + CNT_W'(1);
            rx_shift_d = {rx_shift_q[DATA_W-3:0], din_s};
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              rx_data_d    = {rx_shift_q, din_s};
              valid_pend_d = 1'b1;
              state_d      = ssel_rise ? IDLE : WAIT_DESEL;
            end else if (ssel_rise) begin
              frame_err_d = 1'b1;
              state_d     = IDLE;
            end else begin
              state_d = SHIFT;
            end
          end else if (ssel_rise) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = SHIFT;
          end
        end
        WAIT_DESEL: begin
          if (ssel_rise) begin
            state_d = IDLE;
          end else if (sck_rise && !ovr_q) begin
            frame_err_d = 1'b1;
            ovr_d       = 1'b1;
          end else begin
            state_d = WAIT_DESEL;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Receive-side state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      valid_pend_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ovr_q        <= 1'b0;
      rx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      valid_pend_q <= valid_pend_d;
      frame_err_q  <= frame_err_d;
      ovr_q        <= ovr_d;
      rx_valid_q   <= valid_pend_q & en;
      busy_q       <= (state_d != IDLE);
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

`ifdef SPI_SLAVE_MISO_EN
  logic [DATA_W-2:0] tx_shift_q, tx_shift_d;
  logic              miso_q, miso_d;

  // MSB goes out at frame start; later bits advance on SCK falling edges.
  always_comb begin
    tx_shift_d = tx_shift_q;
    miso_d     = miso_q;
    if (state_q == IDLE && state_d == SHIFT) begin
      tx_shift_d = tx_data[DATA_W-2:0];
      miso_d     = tx_data[DATA_W-1];
    end else if (state_q == SHIFT && state_d == SHIFT && sck_fall) begin
      tx_shift_d = {tx_shift_q[DATA_W-3:0], 1'b0};
      miso_d     = tx_shift_q[DATA_W-2];
    end else if (state_d == IDLE) begin
      miso_d = 1'b0;
    end else begin
      tx_shift_d = tx_shift_q;
    end
  end

  // Transmit shift register and MISO output flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift_q <= '0;
      miso_q     <= 1'b0;
    end else begin
      tx_shift_q <= tx_shift_d;
      miso_q     <= miso_d;
    end
  end

  assign MISO = miso_q;
`else
  logic unused_tx;
  assign unused_tx = ^{tx_data, sck_fall};
  assign MISO      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a master model pushes expected words/errors,
// a monitor pops and compares whenever rx_valid or frame_err is presented.
module tb_spi_slave;

  localparam int W  = 32;
  localparam int HP = 4;

  logic         clk = 1'b0;
  logic         reset_n, en, SCK, SSEL, DATA_IN;
  logic [W-1:0] tx_data;
  logic         MISO, rx_valid, frame_err, busy;
  logic [W-1:0] rx_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_drops = 0;
  logic busy_prev = 1'b0;

  logic [W-1:0] exp_q[$];
  int           t32_q[$];
  int           err_q[$];

  spi_slave dut (
    .clk(clk), .reset_n(reset_n), .en(en), .SCK(SCK), .SSEL(SSEL),
    .DATA_IN(DATA_IN), .tx_data(tx_data), .MISO(MISO), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] miso_exp(input logic [W-1:0] tx);
`ifdef SPI_SLAVE_MISO_EN
    return tx;
`else
    return 32'h0000_0000 & tx;
`endif
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (reset_n) begin
      busy_prev <= busy;
      if (busy_prev && !busy) busy_drops <= busy_drops + 1;
      if (rx_valid && frame_err) check("valid_err_exclusive", 32'd1, 32'd0);
      if (rx_valid) begin
        check("rx_valid_expected", exp_q.size(), 32'd1);
        if (exp_q.size() > 0) begin
          check("rx_data", rx_data, exp_q.pop_front());
          check("rx_latency", cyc - t32_q.pop_front(), 32'd4);
        end
      end
      if (frame_err) begin
        check("frame_err_expected", err_q.size(), 32'd1);
        if (err_q.size() > 0) void'(err_q.pop_front());
      end
    end
  end

  // Master model: nbits SCK pulses MSB first; abort_at>0 pulses reset after that bit.
  task automatic frame(input logic [W-1:0] word, input int nbits, input int abort_at,
                       input logic [W-1:0] tx, input int gap);
    logic [W-1:0] miso_w;
    miso_w  = '0;
    tx_data = tx;
    SSEL    = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_in_frame", busy, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      DATA_IN = (i < W) ? word[W-1-i] : 1'b1;
      repeat (HP) @(negedge clk);
      if (i < W) miso_w = {miso_w[W-2:0], MISO};
      SCK = 1'b1;
      if (i == W - 1) begin
        exp_q.push_back(word);
        t32_q.push_back(cyc);
      end
      if (i == W) err_q.push_back(1);
      if (i + 1 == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_rx_valid", rx_valid, 32'd0);
        check("rst_frame_err", frame_err, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_miso", MISO, 32'd0);
        SCK  = 1'b0;
        SSEL = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        return;
      end
      repeat (HP) @(negedge clk);
      SCK = 1'b0;
    end
    repeat (HP) @(negedge clk);
    if (nbits < W) err_q.push_back(1);
    SSEL = 1'b1;
    if (nbits >= W) check("miso_word", miso_w, miso_exp(tx));
    repeat (gap) @(negedge clk);
    if (gap >= 6) check("busy_after_frame", busy, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drops0;
    reset_n = 1'b0; en = 1'b1; SCK = 1'b0; SSEL = 1'b1; DATA_IN = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 32'd0);
    check("reset_rx_valid", rx_valid, 32'd0);
    check("reset_frame_err", frame_err, 32'd0);
    check("reset_busy", busy, 32'd0);
    check("reset_miso", MISO, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    frame(32'hA5C3_0F81, 32, 0, 32'hDEAD_BEEF, 8);

    drops0 = busy_drops;
    frame(32'h0000_0001, 32, 0, 32'h8000_0001, 2);
    frame(32'hFFFF_FFFE, 32, 0, 32'h1234_ABCD, 8);
    check("busy_drops_b2b", busy_drops - drops0, 32'd2);

    frame(32'h5555_AAAA, 17, 0, 32'h0, 8);
    check("short_keeps_rx_data", rx_data, 32'hFFFF_FFFE);

    frame(32'h3C5A_96E1, 34, 0, 32'hF0F0_0F0F, 8);
    check("overrun_rx_data", rx_data, 32'h3C5A_96E1);

    frame(32'hCAFE_F00D, 32, 10, 32'h0, 0);
    frame(32'h1234_5678, 32, 0, 32'h0BAD_CAFE, 8);

    // en low mid-frame aborts; SSEL already low when en returns is ignored.
    SSEL = 1'b0;
    repeat (6) @(negedge clk);
    check("en_busy_before", busy, 32'd1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("en_low_busy", busy, 32'd0);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) en = 1'b1;
      SCK = 1'b1;
      repeat (HP) @(negedge clk);
      SCK = 1'b0;
      repeat (HP) @(negedge clk);
    end
    check("en_ssel_low_ignored", busy, 32'd0);
    SSEL = 1'b1;

    repeat (10) @(negedge clk);
    check("rx_queue_empty", exp_q.size(), 32'd0);
    check("err_queue_empty", err_q.size(), 32'd0);
    check("final_rx_data", rx_data, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
